// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_rd_arbiter                                               |
// | Description : Shares one AXI read channel between icache and dcache.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axi_rd_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic        ic_rd_req,
  input  logic [2:0]  ic_rd_type,
  input  logic [31:0] ic_rd_addr,
  output logic        ic_rd_rdy,
  output logic        ic_ret_valid,
  output logic        ic_ret_last,
  output logic [31:0] ic_ret_data,
  input  logic        dc_rd_req,
  input  logic [2:0]  dc_rd_type,
  input  logic [31:0] dc_rd_addr,
  output logic        dc_rd_rdy,
  output logic        dc_ret_valid,
  output logic        dc_ret_last,
  output logic [31:0] dc_ret_data,
  input  logic        wr_busy,
  input  logic [31:0] wr_addr,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [0:0] AR_IDLE      = 1'b0;
  localparam logic [0:0] AR_SEND      = 1'b1;
  localparam logic [3:0] c_id_ic      = 4'd0;
  localparam logic [3:0] c_id_dc      = 4'd1;
  localparam logic [2:0] c_type_line  = 3'b100;
  localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic        r_ic_busy;
  logic        r_dc_busy;
  logic [3:0]  r_starve_cnt;
  logic [3:0]  r_arid;
  logic [31:0] r_araddr;
  logic [7:0]  r_arlen;
  logic [2:0]  r_arsize;
  logic        w_ic_elig;
  logic        w_dc_elig;
  logic        w_grant_ic;
  logic        w_grant_dc;
  logic        w_ar_hs;
  logic [31:0] w_win_addr;
  logic [2:0]  w_win_type;
  logic        w_unused;

  // A read may not overtake a pending write to the same 16-byte line.
  assign w_ic_elig = ic_rd_req & ~r_ic_busy & ~(wr_busy & (ic_rd_addr[31:4] == wr_addr[31:4]));
  assign w_dc_elig = dc_rd_req & ~r_dc_busy & ~(wr_busy & (dc_rd_addr[31:4] == wr_addr[31:4]));

  always_comb begin
    w_grant_ic = 1'b0;
    w_grant_dc = 1'b0;
    if (r_state == AR_IDLE) begin
      w_grant_ic = w_ic_elig & (~w_dc_elig | (r_starve_cnt == c_starve_max));
      w_grant_dc = w_dc_elig & ~w_grant_ic;
    end
  end

  assign w_win_addr = w_grant_dc ? dc_rd_addr : ic_rd_addr;
  assign w_win_type = w_grant_dc ? dc_rd_type : ic_rd_type;

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state <= AR_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      AR_IDLE: if (w_grant_ic | w_grant_dc) w_state_nxt = AR_SEND;
      AR_SEND: if (arready) w_state_nxt = AR_IDLE;
      default: w_state_nxt = AR_IDLE;
    endcase
  end

  always_comb begin
    arvalid = (r_state == AR_SEND);
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_arid   <= 4'd0;
      r_araddr <= 32'd0;
      r_arlen  <= 8'd0;
      r_arsize <= 3'd0;
    end else if (w_grant_ic | w_grant_dc) begin
      r_arid   <= w_grant_dc ? c_id_dc : c_id_ic;
      r_araddr <= w_win_addr;
      r_arlen  <= (w_win_type == c_type_line) ? 8'd3 : 8'd0;
      r_arsize <= (w_win_type == c_type_line) ? 3'd2 : {1'b0, w_win_type[1:0]};
    end
  end

  // Counts dcache wins that left a ready icache waiting.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant_ic) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant_dc & w_ic_elig & (r_starve_cnt != c_starve_max)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  assign w_ar_hs   = arvalid & arready;
  assign ic_rd_rdy = w_ar_hs & ~r_arid[0];
  assign dc_rd_rdy = w_ar_hs & r_arid[0];

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_ic_busy <= 1'b0;
      r_dc_busy <= 1'b0;
    end else begin
      if (ic_rd_rdy) r_ic_busy <= 1'b1;
      else if (ic_ret_last) r_ic_busy <= 1'b0;
      if (dc_rd_rdy) r_dc_busy <= 1'b1;
      else if (dc_ret_last) r_dc_busy <= 1'b0;
    end
  end

  assign rready       = ~reset;
  assign ic_ret_valid = rvalid & rready & r_ic_busy & ~rid[0];
  assign dc_ret_valid = rvalid & rready & r_dc_busy & rid[0];
  assign ic_ret_last  = ic_ret_valid & rlast;
  assign dc_ret_last  = dc_ret_valid & rlast;
  assign ic_ret_data  = rdata;
  assign dc_ret_data  = rdata;

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arsize  = r_arsize;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign w_unused = ^{rid[3:1], rresp};

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axi_rd_arbiter                                            |
// | Description : Bench for axi_rd_arbiter with transaction-level model.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_axi_rd_arbiter;
  localparam int STARVE_MAX = 4;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic        ic_rd_req = 0, dc_rd_req = 0, wr_busy = 0, arready = 0, rlast = 0, rvalid = 0;
  logic [2:0]  ic_rd_type = 0, dc_rd_type = 0;
  logic [31:0] ic_rd_addr = 0, dc_rd_addr = 0, wr_addr = 0, rdata = 0;
  logic [3:0]  rid = 0;
  logic [1:0]  rresp = 0;
  logic        ic_rd_rdy, ic_ret_valid, ic_ret_last, dc_rd_rdy, dc_ret_valid, dc_ret_last;
  logic [31:0] ic_ret_data, dc_ret_data, araddr;
  logic [3:0]  arid, arcache;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, rready;

  axi_rd_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .aclk(aclk), .reset(reset),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
    .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
    .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
    .wr_busy(wr_busy), .wr_addr(wr_addr),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: one pending AR record, per-requester busy, starve count.
  bit          m_pend = 0;
  logic [3:0]  m_id = 0;
  logic [31:0] m_addr = 0;
  logic [7:0]  m_len = 0;
  logic [2:0]  m_size = 0;
  bit          m_busy [2];
  int          m_starve = 0;
  bit          ic_done = 0, dc_done = 0;
  int          rem [2];
  ar_t         log_q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit elig(bit req, bit busy, logic [31:0] a);
    return req && !busy && !(wr_busy && (a[31:4] == wr_addr[31:4]));
  endfunction

  task automatic compare();
    bit hs, icv, dcv;
    ar_t e;
    hs  = m_pend && arready;
    icv = rvalid && !reset && m_busy[0] && (rid[0] == 1'b0);
    dcv = rvalid && !reset && m_busy[1] && (rid[0] == 1'b1);
    chk("arvalid", arvalid, m_pend);
    chk("arid", arid, m_id);
    chk("araddr", araddr, m_addr);
    chk("arlen", arlen, m_len);
    chk("arsize", arsize, m_size);
    chk("arburst", arburst, 2'b01);
    chk("arlock_cache_prot", {arlock, arcache, arprot}, 0);
    chk("ic_rd_rdy", ic_rd_rdy, hs && m_id[0] == 1'b0);
    chk("dc_rd_rdy", dc_rd_rdy, hs && m_id[0] == 1'b1);
    chk("rready", rready, !reset);
    chk("ic_ret_valid", ic_ret_valid, icv);
    chk("ic_ret_last", ic_ret_last, icv && rlast);
    chk("dc_ret_valid", dc_ret_valid, dcv);
    chk("dc_ret_last", dc_ret_last, dcv && rlast);
    if (icv) chk("ic_ret_data", ic_ret_data, rdata);
    if (dcv) chk("dc_ret_data", dc_ret_data, rdata);
    if (arvalid && arready) begin
      e.id = arid; e.addr = araddr; e.len = arlen; e.size = arsize;
      log_q.push_back(e);
    end
  endtask

  task automatic model_update();
    bit ic_e, dc_e, pick_ic;
    bit clr [2];
    logic [2:0] t;
    ic_done = m_pend && arready && m_id[0] == 1'b0;
    dc_done = m_pend && arready && m_id[0] == 1'b1;
    if (reset) begin
      m_pend = 0; m_id = 0; m_addr = 0; m_len = 0; m_size = 0;
      m_busy[0] = 0; m_busy[1] = 0; m_starve = 0;
    end else begin
      ic_e = elig(ic_rd_req, m_busy[0], ic_rd_addr);
      dc_e = elig(dc_rd_req, m_busy[1], dc_rd_addr);
      for (int i = 0; i < 2; i++) clr[i] = rvalid && m_busy[i] && (rid[0] == i[0]) && rlast;
      if (m_pend) begin
        if (arready) begin
          m_pend = 0;
          m_busy[m_id[0]] = 1;
          rem[m_id[0]] = int'(m_len) + 1;
        end
      end else if (ic_e || dc_e) begin
        pick_ic = ic_e && (!dc_e || m_starve == STARVE_MAX);
        if (pick_ic) m_starve = 0;
        else if (ic_e && m_starve < STARVE_MAX) m_starve++;
        m_id   = pick_ic ? 4'd0 : 4'd1;
        m_addr = pick_ic ? ic_rd_addr : dc_rd_addr;
        t      = pick_ic ? ic_rd_type : dc_rd_type;
        m_len  = (t == 3'b100) ? 8'd3 : 8'd0;
        m_size = (t == 3'b100) ? 3'd2 : {1'b0, t[1:0]};
        m_pend = 1;
      end
      for (int i = 0; i < 2; i++) if (clr[i]) m_busy[i] = 0;
    end
  endtask

  task automatic cycle();
    @(negedge aclk);
    compare();
    @(posedge aclk);
    model_update();
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [1:0] ln;
    logic [3:0] off;
    ln  = 2'($urandom_range(0, 3));
    off = 4'($urandom_range(0, 15));
    return {24'h1C0080, 2'b00, ln, off};
  endfunction

  function automatic logic [2:0] rand_type();
    case ($urandom_range(0, 3))
      0: return 3'b000;
      1: return 3'b001;
      2: return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic drive_r(bit rnd);
    int cand[$];
    int id;
    logic [2:0] hi;
    rvalid = 0; rlast = 0;
    hi = 3'($urandom_range(0, 7));
    for (int i = 0; i < 2; i++) if (rem[i] > 0) cand.push_back(i);
    if (cand.size() > 0 && (!rnd || $urandom_range(0, 9) < 6)) begin
      id = cand[$urandom_range(0, cand.size() - 1)];
      rvalid = 1; rid = {hi, id[0]}; rlast = (rem[id] == 1); rdata = $urandom; rem[id]--;
    end else if (rnd && $urandom_range(0, 9) == 0) begin
      id = $urandom_range(0, 1);
      if (rem[id] == 0) begin
        rvalid = 1; rid = {hi, id[0]}; rlast = $urandom_range(0, 1); rdata = $urandom;
      end
    end
  endtask

  // mode 0: drop requests once accepted; 1: starvation scenario; 2: random traffic
  task automatic step(int mode, bit auto_r);
    if (mode == 2) begin
      reset   = ($urandom_range(0, 399) == 0);
      arready = $urandom_range(0, 1);
      wr_busy = ($urandom_range(0, 3) == 0);
      wr_addr = rand_addr();
      if (ic_done || !ic_rd_req) begin
        ic_rd_req = ($urandom_range(0, 2) != 0); ic_rd_addr = rand_addr(); ic_rd_type = rand_type();
      end
      if (dc_done || !dc_rd_req) begin
        dc_rd_req = ($urandom_range(0, 2) != 0); dc_rd_addr = rand_addr(); dc_rd_type = rand_type();
      end
    end else begin
      if (ic_done) ic_rd_req = 0;
      if (dc_done) begin
        if (mode == 1) dc_rd_addr = {24'h1C0080, 4'($urandom_range(0, 15)), 4'h0};
        else dc_rd_req = 0;
      end
      if (mode == 1) begin
        wr_busy = m_busy[1];
        wr_addr = ic_rd_addr;
      end
    end
    if (auto_r) drive_r(mode == 2);
    else begin rvalid = 0; rlast = 0; end
    cycle();
  endtask

  task automatic beat(string name, logic id, logic last, bit exp_ic, bit exp_dc);
    rvalid = 1; rid = {3'b000, id}; rlast = last; rdata = $urandom;
    #1;
    chk({name, "_icv"}, ic_ret_valid, exp_ic);
    chk({name, "_dcv"}, dc_ret_valid, exp_dc);
    chk({name, "_last"}, ic_ret_last | dc_ret_last, last & (exp_ic | exp_dc));
    cycle();
    rvalid = 0; rlast = 0;
  endtask

  initial begin
    m_busy[0] = 0; m_busy[1] = 0; rem[0] = 0; rem[1] = 0;
    @(posedge aclk); model_update(); #1;
    cycle();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arburst", arburst, 2'b01);
    chk("rst_rready", rready, 0);
    reset = 0;
    cycle();

    // Icache line read alone
    ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0000; arready = 0;
    cycle();
    chk("d1_arvalid", arvalid, 1);
    chk("d1_arid", arid, 0);
    chk("d1_arlen", arlen, 3);
    chk("d1_arsize", arsize, 2);
    arready = 1; #1;
    chk("d1_rdy", ic_rd_rdy, 1);
    cycle();
    ic_rd_req = 0; arready = 0;
    for (int k = 0; k < 4; k++) beat("d1_beat", 1'b0, k == 3, 1, 0);
    beat("d1_after", 1'b0, 1'b1, 0, 0);
    rem[0] = 0; rem[1] = 0;

    // Simultaneous requests: dcache goes first
    log_q.delete();
    arready = 1;
    dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h1C00_8000;
    ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0000;
    for (int i = 0; i < 12; i++) step(0, 1);
    chk("d2_count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("d2_first_id", log_q[0].id, 1);
      chk("d2_first_len_size", {log_q[0].len, log_q[0].size}, {8'd0, 3'd2});
      chk("d2_second_id", log_q[1].id, 0);
    end

    // Starvation: four dcache wins then icache is forced through
    log_q.delete();
    dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h1C00_8010;
    ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0040;
    for (int i = 0; i < 100 && log_q.size() < 5; i++) step(1, 1);
    chk("d3_count", log_q.size(), 5);
    if (log_q.size() >= 5)
      chk("d3_ids", {log_q[0].id[0], log_q[1].id[0], log_q[2].id[0], log_q[3].id[0], log_q[4].id[0]}, 5'b11110);
    dc_rd_req = 0; ic_rd_req = 0; wr_busy = 0;
    for (int i = 0; i < 12; i++) step(0, 1);

    // Read blocked by a pending write to the same line
    log_q.delete();
    wr_busy = 1; wr_addr = 32'h1C00_8004;
    dc_rd_req = 1; dc_rd_type = 3'b000; dc_rd_addr = 32'h1C00_800C;
    for (int i = 0; i < 5; i++) step(0, 1);
    chk("d4_blocked", log_q.size(), 0);
    chk("d4_arvalid_lo", arvalid, 0);
    wr_busy = 0;
    cycle();
    chk("d4_arvalid", arvalid, 1);
    chk("d4_araddr", araddr, 32'h1C00_800C);
    chk("d4_arsize", arsize, 0);
    for (int i = 0; i < 8; i++) step(0, 1);

    // Interleaved returns
    log_q.delete();
    ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0080;
    for (int i = 0; i < 3; i++) step(0, 0);
    dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h1C00_80C0;
    for (int i = 0; i < 3; i++) step(0, 0);
    chk("d5_count", log_q.size(), 2);
    beat("d5_b0", 1'b0, 1'b0, 1, 0);
    beat("d5_b1", 1'b1, 1'b1, 0, 1);
    beat("d5_b2", 1'b0, 1'b0, 1, 0);
    beat("d5_b3", 1'b0, 1'b0, 1, 0);
    beat("d5_b4", 1'b0, 1'b1, 1, 0);
    beat("d5_ic_clear", 1'b0, 1'b1, 0, 0);
    beat("d5_dc_clear", 1'b1, 1'b1, 0, 0);
    rem[0] = 0; rem[1] = 0;

    // Reset in the middle of a line return
    ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0100;
    for (int i = 0; i < 3; i++) step(0, 0);
    beat("d6_b0", 1'b0, 1'b0, 1, 0);
    reset = 1;
    beat("d6_b1", 1'b0, 1'b0, 0, 0);
    reset = 0;
    chk("d6_arvalid", arvalid, 0);
    beat("d6_b2", 1'b0, 1'b0, 0, 0);
    beat("d6_b3", 1'b0, 1'b1, 0, 0);
    rem[0] = 0; rem[1] = 0;

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) step(2, 1);
    reset = 0; ic_rd_req = 0; dc_rd_req = 0; wr_busy = 0; arready = 1;
    for (int i = 0; i < 20; i++) step(0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
Shares the single AXI read address/data channel pair of the memory bridge between the instruction cache and the data cache read miss/uncached paths. Arbitrates AR requests with data-first priority and an anti-starvation counter, and tracks one outstanding transaction per requester. Routes R beats back by ID and blocks reads that hit a line still being written.
Sits between the two caches and the AXI read ports of the bridge.

Parameters:
STARVE_MAX, 4, consecutive dcache grants allowed while icache waits before icache is forced to win (1..15)

Ports:
aclk  in  1  clock
reset  in  1  synchronous, active-high reset
ic_rd_req  in  1  icache read request
ic_rd_type  in  3  000 byte, 001 half, 010 word, 100 16-byte line
ic_rd_addr  in  32  icache read address
ic_rd_rdy  out  1  icache request accepted (AR handshake pulse)
ic_ret_valid  out  1  icache return beat valid
ic_ret_last  out  1  last icache beat
ic_ret_data  out  32  icache return data
dc_rd_req  in  1  dcache read request
dc_rd_type  in  3  encoding as ic_rd_type
dc_rd_addr  in  32  dcache read address
dc_rd_rdy  out  1  dcache request accepted
dc_ret_valid  out  1  dcache return beat valid
dc_ret_last  out  1  last dcache beat
dc_ret_data  out  32  dcache return data
wr_busy  in  1  write path has an unfinished write
wr_addr  in  32  address of that write
arid  out  4  0 = icache, 1 = dcache
araddr  out  32  read address
arlen  out  8  3 for line, 0 otherwise
arsize  out  3  2 for line, {0,type[1:0]} otherwise
arburst  out  2  constant 2'b01
arlock  out  2  constant 0
arcache  out  4  constant 0
arprot  out  3  constant 0
arvalid  out  1  address valid
arready  in  1  address ready
rid  in  4  response ID
rdata  in  32  response data
rresp  in  2  ignored
rlast  in  1  last beat
rvalid  in  1  beat valid
rready  out  1  beat ready

Behaviour:
- Reset: state AR_IDLE; arvalid=0, arid=0, araddr=0, arlen=0, arsize=0, arburst=01; ic_busy=dc_busy=0; starve_cnt=0; all rdy/ret outputs 0. Reset mid-burst drops all outstanding state; in-flight beats after reset are accepted and discarded.
- Eligibility: X eligible = X_rd_req & ~X_busy & ~(wr_busy & X_rd_addr[31:4]==wr_addr[31:4]).
- Arbitration (AR_IDLE only): if both eligible, dcache wins unless starve_cnt==STARVE_MAX, then icache wins. Single eligible requester wins. No eligible requester: stay in AR_IDLE.
- starve_cnt: +1 when dcache is granted while icache is eligible; cleared when icache is granted; saturates at STARVE_MAX.
- States: AR_IDLE --grant--> AR_SEND, latching arid/araddr/arlen/arsize from the winner on that edge. AR_SEND: arvalid=1, fields stable. On arvalid&arready: return to AR_IDLE and set winner busy. There is a minimum of one idle cycle between AR handshakes.
- X_rd_rdy = arvalid & arready & (arid[0]==X's ID). It is a one-cycle pulse. The requester holds its request until rdy is seen.
- Type mapping: type 100 gives arlen=3, arsize=2. Otherwise arlen=0, arsize={0,type[1:0]}. araddr is passed unaligned.
- R channel: rready = ~reset (always 1 after reset). X_ret_valid = rvalid & rready & X_busy & rid[0]==ID. X_ret_last = X_ret_valid & rlast. X_ret_data = rdata. All are combinational with zero latency. rid[3:1] is ignored.
- X_busy clears on X_ret_valid & rlast. Set and clear for different IDs in the same cycle are both applied. Set and clear for the same ID cannot coincide.
- Beat with no matching busy flag: consumed (rready=1) and dropped, with no ret_valid.
- Interleaved beats from IDs 0 and 1 are routed per beat.

Test Plan:
- Icache line read 0x1C000000 only → arid=0, arlen=3, arsize=2. With the handshake at cycle n, ic_rd_rdy pulses at cycle n. 4 R beats (rid=0, rlast on beat 4) → ic_ret_valid ×4, ic_ret_last on beat 4, ic_busy cleared.
- Both request simultaneously (dc word 0x1C008000, ic line) → dcache issued first (arid=1, arlen=0, arsize=2). Icache is issued at the next AR_IDLE.
- dc_rd_req held continuously with new addresses, ic_rd_req held, STARVE_MAX=4 → 4 dcache grants, then icache grant, then starve_cnt=0.
- wr_busy=1, wr_addr=0x1C008004, dc byte read 0x1C00800C → no AR issued. Drop wr_busy → AR issued next AR_IDLE cycle with arsize=0.
- Outstanding icache line read, then dcache word issued; R beats interleave (rid 0,1,0,0,0) → each beat is routed to the correct port, dc_ret_last is asserted on the rid=1 beat, and both busy flags clear.
- Reset asserted during the 2nd beat of an icache line → arvalid=0, ic_busy=0. Remaining beats produce no ic_ret_valid.
